// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall controller bundle: pipeline hazard inputs, cache miss handshakes, and the
// stage write-enable/flush controls driven back to the pipeline.
interface hazard_stall_unit_if;
    logic [3:0]  IF_ID_Rs;
    logic [3:0]  IF_ID_Rt;
    logic        IF_ID_UsesRt;
    logic        IF_ID_BranchReg;
    logic        br_taken;
    logic        ID_EX_MemRead;
    logic        ID_EX_RegWrite;
    logic [3:0]  ID_EX_WriteRegister;
    logic        EX_MEM_MemRead;
    logic [3:0]  EX_MEM_WriteRegister;
    logic        icache_miss;
    logic        dcache_miss;
    logic        icache_ready;
    logic        dcache_ready;
    logic        pc_we;
    logic        if_id_we;
    logic        id_ex_we;
    logic        ex_mem_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        miss_timeout;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_BranchReg, br_taken,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_WriteRegister,
               EX_MEM_MemRead, EX_MEM_WriteRegister,
               icache_miss, dcache_miss, icache_ready, dcache_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_flush, mem_wb_flush,
               miss_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_BranchReg, br_taken,
               ID_EX_MemRead, ID_EX_RegWrite, ID_EX_WriteRegister,
               EX_MEM_MemRead, EX_MEM_WriteRegister,
               icache_miss, dcache_miss, icache_ready, dcache_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_flush, mem_wb_flush,
               miss_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller for the 5-stage core: load-use, BR dependency, branch flush and
// cache-miss freezes with a miss watchdog. Define HAZARD_PERF_CNT_EN to build perf counters.
module hazard_stall_unit #(
    parameter int unsigned MISS_TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_unit_if.slave hz
);

    localparam int unsigned WdW = ($clog2(MISS_TIMEOUT + 1) > 8) ? $clog2(MISS_TIMEOUT + 1) : 8;
    localparam int unsigned WdLimitInt = (MISS_TIMEOUT > 0) ? MISS_TIMEOUT - 1 : 0;
    localparam logic [WdW-1:0] WdLimit = WdW'(WdLimitInt);
    localparam logic [WdW-1:0] WdMax = '1;

    typedef enum logic [1:0] {StRun, StDmiss, StImiss} stateT;

    stateT          stateQ, stateD;
    logic [WdW-1:0] wdQ, wdD;
    logic           timeoutQ, timeoutD;

    logic loadUse, brDep, dataStall, dFreeze, iFreeze;
    logic pcWe, ifIdWe, idExWe, exMemWe, ifIdFlush, idExFlush, memWbFlush;

    assign loadUse = hz.ID_EX_MemRead && (hz.ID_EX_WriteRegister != 4'd0) &&
                     ((hz.ID_EX_WriteRegister == hz.IF_ID_Rs) ||
                      (hz.IF_ID_UsesRt && (hz.ID_EX_WriteRegister == hz.IF_ID_Rt)));

    assign brDep = hz.IF_ID_BranchReg && (hz.IF_ID_Rs != 4'd0) &&
                   ((hz.ID_EX_RegWrite && (hz.ID_EX_WriteRegister == hz.IF_ID_Rs)) ||
                    (hz.EX_MEM_MemRead && (hz.EX_MEM_WriteRegister == hz.IF_ID_Rs)));

    assign dataStall = loadUse || brDep;

    // A D-miss rising in RUN or IMISS freezes immediately; it belongs to the older instruction.
    assign dFreeze = (stateQ == StDmiss) || hz.dcache_miss;
    assign iFreeze = (stateQ == StImiss) || ((stateQ == StRun) && hz.icache_miss);

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StRun: begin
                if (hz.dcache_miss) stateD = StDmiss;
                else if (hz.icache_miss) stateD = StImiss;
            end
            StDmiss: begin
                if (hz.dcache_ready) stateD = hz.icache_miss ? StImiss : StRun;
            end
            StImiss: begin
                if (hz.dcache_miss) stateD = StDmiss;
                else if (hz.icache_ready) stateD = StRun;
            end
            default: stateD = StRun;
        endcase
    end

    always_comb begin
        pcWe       = 1'b0;
        ifIdWe     = 1'b0;
        idExWe     = 1'b0;
        exMemWe    = 1'b0;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        memWbFlush = 1'b0;
        if (!rst_n) begin
            pcWe = 1'b0;
        end else if (dFreeze) begin
            memWbFlush = 1'b1;
        end else if (dataStall) begin
            idExWe    = 1'b1;
            exMemWe   = 1'b1;
            idExFlush = 1'b1;
        end else if (iFreeze) begin
            ifIdWe    = 1'b1;
            idExWe    = 1'b1;
            exMemWe   = 1'b1;
            ifIdFlush = 1'b1;
        end else begin
            pcWe      = 1'b1;
            ifIdWe    = 1'b1;
            idExWe    = 1'b1;
            exMemWe   = 1'b1;
            ifIdFlush = hz.br_taken;
        end
    end

    // Watchdog counts miss-state cycles; together with the rise cycle, a miss that has
    // lasted MISS_TIMEOUT cycles sets the sticky error at the end of that cycle.
    always_comb begin
        wdD = wdQ;
        if (stateD != stateQ) wdD = '0;
        else if ((stateQ != StRun) && (wdQ != WdMax)) wdD = wdQ + WdW'(1);
        timeoutD = timeoutQ ||
                   ((stateQ != StRun) && (stateD == stateQ) && (wdD >= WdLimit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StRun;
            wdQ      <= '0;
            timeoutQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            wdQ      <= wdD;
            timeoutQ <= timeoutD;
        end
    end

    assign hz.pc_we        = pcWe;
    assign hz.if_id_we     = ifIdWe;
    assign hz.id_ex_we     = idExWe;
    assign hz.ex_mem_we    = exMemWe;
    assign hz.if_id_flush  = ifIdFlush;
    assign hz.id_ex_flush  = idExFlush;
    assign hz.mem_wb_flush = memWbFlush;
    assign hz.miss_timeout = timeoutQ;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCntQ, flushCntQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (!pcWe && (stallCntQ != 16'hFFFF)) stallCntQ <= stallCntQ + 16'd1;
            if ((ifIdFlush || idExFlush || memWbFlush) && (flushCntQ != 16'hFFFF)) begin
                flushCntQ <= flushCntQ + 16'd1;
            end
        end
    end

    assign hz.stall_cycles = stallCntQ;
    assign hz.flush_count  = flushCntQ;
`else
    assign hz.stall_cycles = 16'd0;
    assign hz.flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares them against the combinational controls.
module tb_hazard_stall_unit;

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush}
    localparam logic [6:0] Norm  = 7'b1111_000;
    localparam logic [6:0] Stall = 7'b0011_010;
    localparam logic [6:0] IMiss = 7'b0111_100;
    localparam logic [6:0] BrTkn = 7'b1111_100;
    localparam logic [6:0] DFrz  = 7'b0000_001;
    localparam logic [6:0] InRst = 7'b0000_000;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [15:0] DMissCnt = 16'd10;
`else
    localparam logic [15:0] DMissCnt = 16'd0;
`endif

    typedef struct {
        string       nm;
        logic [6:0]  ctl;
        bit          chkTo;
        logic        to;
        bit          chkCnt;
        logic [15:0] st;
        logic [15:0] fl;
    } expT;

    logic clk;
    logic rst_n;
    expT  sbQ[$];
    int   nVec;
    int   nMis;

    hazard_stall_unit_if hzIf();

    hazard_stall_unit #(
        .MISS_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hzIf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, got hang, want completion");
        $fatal(1);
    end

    initial begin
        expT        e;
        logic [6:0] ctl;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e   = sbQ.pop_front();
                ctl = {hzIf.pc_we, hzIf.if_id_we, hzIf.id_ex_we, hzIf.ex_mem_we,
                       hzIf.if_id_flush, hzIf.id_ex_flush, hzIf.mem_wb_flush};
                nVec++;
                if (ctl !== e.ctl) begin
                    nMis++;
                    $display("FAIL %s ctl: got %b want %b", e.nm, ctl, e.ctl);
                end
                if (e.chkTo) begin
                    nVec++;
                    if (hzIf.miss_timeout !== e.to) begin
                        nMis++;
                        $display("FAIL %s miss_timeout: got %b want %b", e.nm,
                                 hzIf.miss_timeout, e.to);
                    end
                end
                if (e.chkCnt) begin
                    nVec += 2;
                    if (hzIf.stall_cycles !== e.st) begin
                        nMis++;
                        $display("FAIL %s stall_cycles: got %0d want %0d", e.nm,
                                 hzIf.stall_cycles, e.st);
                    end
                    if (hzIf.flush_count !== e.fl) begin
                        nMis++;
                        $display("FAIL %s flush_count: got %0d want %0d", e.nm,
                                 hzIf.flush_count, e.fl);
                    end
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic [6:0] ctl, input bit chkTo = 1'b0,
                       input logic to = 1'b0, input bit chkCnt = 1'b0,
                       input logic [15:0] st = 16'd0, input logic [15:0] fl = 16'd0);
        expT e;
        e.nm = nm; e.ctl = ctl; e.chkTo = chkTo; e.to = to;
        e.chkCnt = chkCnt; e.st = st; e.fl = fl;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        hzIf.IF_ID_Rs = 4'd0; hzIf.IF_ID_Rt = 4'd0;
        hzIf.IF_ID_UsesRt = 1'b0; hzIf.IF_ID_BranchReg = 1'b0; hzIf.br_taken = 1'b0;
        hzIf.ID_EX_MemRead = 1'b0; hzIf.ID_EX_RegWrite = 1'b0; hzIf.ID_EX_WriteRegister = 4'd0;
        hzIf.EX_MEM_MemRead = 1'b0; hzIf.EX_MEM_WriteRegister = 4'd0;
        hzIf.icache_miss = 1'b0; hzIf.dcache_miss = 1'b0;
        hzIf.icache_ready = 1'b0; hzIf.dcache_ready = 1'b0;
    endtask

    initial begin
        nVec = 0;
        nMis = 0;
        rst_n = 1'b0;
        clearIn();
        @(posedge clk);
        #1;
        cyc("reset", InRst, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        rst_n = 1'b1;
        cyc("normal", Norm, 1'b1, 1'b0);

        // LW R3 in EX, ADD R5,R3,R4 in ID
        hzIf.ID_EX_MemRead = 1'b1; hzIf.ID_EX_RegWrite = 1'b1; hzIf.ID_EX_WriteRegister = 4'd3;
        hzIf.IF_ID_Rs = 4'd3; hzIf.IF_ID_Rt = 4'd4; hzIf.IF_ID_UsesRt = 1'b1;
        cyc("lu_rs", Stall);
        clearIn();
        cyc("lu_after", Norm);
        // LW R0 never stalls
        hzIf.ID_EX_MemRead = 1'b1; hzIf.ID_EX_WriteRegister = 4'd0;
        hzIf.IF_ID_Rs = 4'd0; hzIf.IF_ID_Rt = 4'd0; hzIf.IF_ID_UsesRt = 1'b1;
        cyc("lu_r0", Norm);
        // dependence through Rt
        hzIf.ID_EX_WriteRegister = 4'd4; hzIf.IF_ID_Rs = 4'd3; hzIf.IF_ID_Rt = 4'd4;
        cyc("lu_rt", Stall);
        // SW R3 after LW R3: Rt not an ALU operand
        hzIf.ID_EX_WriteRegister = 4'd3; hzIf.IF_ID_Rs = 4'd2; hzIf.IF_ID_Rt = 4'd3;
        hzIf.IF_ID_UsesRt = 1'b0;
        cyc("sw_after_lw", Norm);
        clearIn();

        // LW R2 then BR R2: two stall cycles, br_taken ignored while stalled
        hzIf.ID_EX_MemRead = 1'b1; hzIf.ID_EX_RegWrite = 1'b1; hzIf.ID_EX_WriteRegister = 4'd2;
        hzIf.IF_ID_BranchReg = 1'b1; hzIf.IF_ID_Rs = 4'd2; hzIf.br_taken = 1'b1;
        cyc("br_lw_1", Stall);
        hzIf.ID_EX_MemRead = 1'b0; hzIf.ID_EX_RegWrite = 1'b0; hzIf.ID_EX_WriteRegister = 4'd0;
        hzIf.EX_MEM_MemRead = 1'b1; hzIf.EX_MEM_WriteRegister = 4'd2;
        cyc("br_lw_2", Stall);
        hzIf.EX_MEM_MemRead = 1'b0; hzIf.EX_MEM_WriteRegister = 4'd0;
        cyc("br_taken", BrTkn);
        clearIn();
        cyc("br_after", Norm);
        // BR on ALU result: one stall cycle
        hzIf.ID_EX_RegWrite = 1'b1; hzIf.ID_EX_WriteRegister = 4'd6;
        hzIf.IF_ID_BranchReg = 1'b1; hzIf.IF_ID_Rs = 4'd6;
        cyc("br_alu_1", Stall);
        hzIf.ID_EX_RegWrite = 1'b0; hzIf.ID_EX_WriteRegister = 4'd0;
        hzIf.EX_MEM_WriteRegister = 4'd6;
        cyc("br_alu_2", Norm);
        clearIn();
        hzIf.icache_ready = 1'b1;
        cyc("stray_iready", Norm);
        clearIn();

        // D-miss of 10 cycles with counters cleared first
        rst_n = 1'b0;
        cyc("reset2", InRst, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        rst_n = 1'b1;
        hzIf.dcache_miss = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            hzIf.dcache_ready = (k == 10);
            cyc($sformatf("dmiss_%0d", k), DFrz);
        end
        clearIn();
        cyc("dmiss_done", Norm, 1'b1, 1'b0, 1'b1, DMissCnt, DMissCnt);

        // Concurrent misses: D first, then I
        hzIf.dcache_miss = 1'b1; hzIf.icache_miss = 1'b1;
        cyc("both_1", DFrz);
        cyc("both_2", DFrz);
        hzIf.dcache_ready = 1'b1;
        cyc("both_dready", DFrz);
        hzIf.dcache_miss = 1'b0;
        cyc("imiss_stray_dready", IMiss);
        hzIf.dcache_ready = 1'b0;
        hzIf.ID_EX_MemRead = 1'b1; hzIf.ID_EX_WriteRegister = 4'd7; hzIf.IF_ID_Rs = 4'd7;
        cyc("imiss_lu", Stall);
        hzIf.ID_EX_MemRead = 1'b0; hzIf.ID_EX_WriteRegister = 4'd0; hzIf.IF_ID_Rs = 4'd0;
        hzIf.icache_ready = 1'b1;
        cyc("imiss_iready", IMiss);
        clearIn();
        cyc("both_done", Norm, 1'b1, 1'b0);

        // Watchdog: sticky error after 16 miss cycles, cleared only by reset
        hzIf.dcache_miss = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc($sformatf("wd_%0d", k), DFrz, 1'b1, (k >= 17));
        end
        rst_n = 1'b0;
        cyc("wd_rst_1", InRst, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        cyc("wd_rst_2", InRst, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        hzIf.dcache_miss = 1'b0;
        rst_n = 1'b1;
        cyc("wd_post_rst", Norm, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);

        @(negedge clk);
        #1;
        if (sbQ.size() != 0) begin
            nVec++;
            nMis++;
            $display("FAIL drain: got %0d pending, want 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
